// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: controller state encoding
//   and the legal operand-width range.
`timescale 1ns / 1ps

package serial_subtractor_pkg;

  // Legal operand width range
  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 32;

  // Controller states, explicitly encoded in two bits
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic bit width_ok(int unsigned w);
    return (w >= WidthMin) && (w <= WidthMax);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// serial_subtractor_full_subtractor
//   One-bit full subtractor: computes a - b - bin.
//   Ports:
//     a_i    minuend bit
//     b_i    subtrahend bit
//     bin_i  borrow in
//     diff_o difference bit
//     bout_o borrow out
`timescale 1ns / 1ps

module serial_subtractor_full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  always_comb begin
    diff_o = a_i ^ b_i ^ bin_i;
    // Borrow when b beats a outright, or when they tie and a borrow is pending
    bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
  end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per clock
//   through a single full-subtractor cell and a registered borrow.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     start      request an operation; a and b are sampled when accepted
//     a, b       minuend, subtrahend
//     busy       high while shifting
//     done       one-cycle pulse when diff/borrow_out are updated
//     diff       (a - b) mod 2^WIDTH, held until the next completion
//     borrow_out 1 iff a < b (unsigned), held until the next completion
`timescale 1ns / 1ps

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("serial_subtractor: WIDTH out of range");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic             fs_diff;
  logic             fs_bout;
  logic [WIDTH-1:0] res_shift;

  serial_subtractor_full_subtractor u_fs (
    .a_i    (sa_q[0]),
    .b_i    (sb_q[0]),
    .bin_i  (borrow_q),
    .diff_o (fs_diff),
    .bout_o (fs_bout)
  );

  // New difference bit enters at the MSB so the LSB-first stream lands in order
  assign res_shift = {fs_diff, res_q[WIDTH-1:1]};

  always_comb begin
    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    res_d        = res_q;
    borrow_d     = borrow_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        // Accepting in StDone gives back-to-back operation
        if (start) begin
          state_d  = StShift;
          sa_d     = a;
          sb_d     = b;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      StShift: begin
        sa_d     = {1'b0, sa_q[WIDTH-1:1]};
        sb_d     = {1'b0, sb_q[WIDTH-1:1]};
        res_d    = res_shift;
        borrow_d = fs_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d      = StDone;
          diff_d       = res_shift;
          borrow_out_d = fs_bout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sa_q         <= '0;
      sb_q         <= '0;
      res_q        <= '0;
      borrow_q     <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      res_q        <= res_d;
      borrow_q     <= borrow_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign busy       = (state_q == StShift);
  assign done       = (state_q == StDone);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=13,
//   plus an exhaustive check of the full-subtractor cell.
`timescale 1ns / 1ps

module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, busy8, done8, borrow8;
  logic [7:0]  a8, b8, diff8;
  logic        start13, busy13, done13, borrow13;
  logic [12:0] a13, b13, diff13;
  logic        fs_a, fs_b, fs_bin, fs_diff, fs_bout;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (borrow8)
  );

  serial_subtractor #(.WIDTH(13)) u_dut13 (
    .clk        (clk),
    .rst        (rst),
    .start      (start13),
    .a          (a13),
    .b          (b13),
    .busy       (busy13),
    .done       (done13),
    .diff       (diff13),
    .borrow_out (borrow13)
  );

  serial_subtractor_full_subtractor u_fs (
    .a_i    (fs_a),
    .b_i    (fs_b),
    .bin_i  (fs_bin),
    .diff_o (fs_diff),
    .bout_o (fs_bout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_subtractor();
    logic [2:0] v;
    int r;
    logic exp_d, exp_bo;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      fs_a = v[2]; fs_b = v[1]; fs_bin = v[0];
      #1;
      r = int'(v[2]) - int'(v[1]) - int'(v[0]);
      exp_d  = r[0];
      exp_bo = (r < 0);
      checks++;
      if ({fs_bout, fs_diff} !== {exp_bo, exp_d}) begin
        errors++;
        $display("FAIL fs_cell abc=%b got bout/diff=%b%b want %b%b", v, fs_bout, fs_diff,
                 exp_bo, exp_d);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
        errors++;
        $display("FAIL reset8 got busy=%b done=%b diff=%h bo=%b want all 0", busy8, done8,
                 diff8, borrow8);
      end
      checks++;
      if ({busy13, done13, diff13, borrow13} !== 16'd0) begin
        errors++;
        $display("FAIL reset13 got busy=%b done=%b diff=%h bo=%b want all 0", busy13, done13,
                 diff13, borrow13);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    a8 = 8'h35; b8 = 8'h12; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy cycle %0d got busy=%b done=%b want 1 0", c, busy8, done8);
      end
      tick();
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done cycle 9 got done=%b busy=%b want 1 0", done8, busy8);
    end
    checks++;
    if (diff8 !== 8'h23 || borrow8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got %h/%b want 23/0", diff8, borrow8);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== 8'h23) begin
      errors++;
      $display("FAIL basic_after got done=%b busy=%b diff=%h want 0 0 23", done8, busy8, diff8);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] vd [3];
    logic       vo [3];
    int n;
    va[0] = 8'h12; vb[0] = 8'h35; vd[0] = 8'hDD; vo[0] = 1'b1;
    va[1] = 8'h00; vb[1] = 8'h01; vd[1] = 8'hFF; vo[1] = 1'b1;
    va[2] = 8'hFF; vb[2] = 8'hFF; vd[2] = 8'h00; vo[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = va[i]; b8 = vb[i]; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      n = 1;
      while (done8 !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (done8 !== 1'b1 || n != 9) begin
        errors++;
        $display("FAIL vec%0d_latency got done=%b at cycle %0d want 1 at 9", i, done8, n);
      end
      checks++;
      if (diff8 !== vd[i] || borrow8 !== vo[i]) begin
        errors++;
        $display("FAIL vec%0d_result got %h/%b want %h/%b", i, diff8, borrow8, vd[i], vo[i]);
      end
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    // Third SHIFT cycle: a second request must be ignored
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 4;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (done8 !== 1'b1 || n != 9) begin
      errors++;
      $display("FAIL ignore_latency got done=%b at cycle %0d want 1 at 9", done8, n);
    end
    checks++;
    if (diff8 !== 8'h7F || borrow8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result got %h/%b want 7f/0", diff8, borrow8);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    a8 = 8'h40; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (diff8 !== 8'h7F || borrow8 !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d got %h/%b want 7f/0", c, diff8, borrow8);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      errors++;
      $display("FAIL midreset got busy=%b done=%b diff=%h bo=%b want all 0", busy8, done8,
               diff8, borrow8);
    end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet got activity=%b want 0", seen);
    end
    // Reset and start on the same edge: reset wins
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1; rst = 1'b1;
    tick();
    start8 = 1'b0; rst = 1'b0;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_vs_start got busy=%b want 0", busy8);
    end
    tick();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_vs_start_after got busy=%b done=%b want 0 0", busy8, done8);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    tick();
    n = 1;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (done8 !== 1'b1 || n != 9 || diff8 !== 8'h0F || borrow8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got done=%b cycle=%0d res=%h/%b want 1 9 0f/0", done8, n, diff8,
               borrow8);
    end
    a8 = 8'h05; b8 = 8'h07;
    tick();
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b want 1", busy8);
    end
    n = 1;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (done8 !== 1'b1 || n != 9 || diff8 !== 8'hFE || borrow8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got done=%b cycle=%0d res=%h/%b want 1 9 fe/1", done8, n, diff8,
               borrow8);
    end
    tick();
  endtask

  task automatic test_random8();
    logic [7:0] ra, rb, ed;
    logic eb;
    int n;
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    a8 = ra; b8 = rb; start8 = 1'b1;
    tick();
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      ed = ra - rb;
      eb = (ra < rb);
      while (done8 !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (done8 !== 1'b1 || n != 9) begin
        errors++;
        $display("FAIL rand8_spacing op %0d got done=%b at %0d want 1 at 9", i, done8, n);
        break;
      end
      checks++;
      if (diff8 !== ed || borrow8 !== eb) begin
        errors++;
        $display("FAIL rand8 %h-%h got %h/%b want %h/%b", ra, rb, diff8, borrow8, ed, eb);
      end
      if (i == 999) begin
        start8 = 1'b0;
      end else begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        a8 = ra; b8 = rb;
      end
      tick();
      n = 1;
    end
    start8 = 1'b0;
    for (int c = 0; c < 12; c++) tick();
  endtask

  task automatic test_random13();
    logic [12:0] ra, rb, ed;
    logic eb;
    int n;
    ra = 13'($urandom_range(0, 8191));
    rb = 13'($urandom_range(0, 8191));
    a13 = ra; b13 = rb; start13 = 1'b1;
    tick();
    n = 1;
    for (int i = 0; i < 1000; i++) begin
      ed = ra - rb;
      eb = (ra < rb);
      while (done13 !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (done13 !== 1'b1 || n != 14) begin
        errors++;
        $display("FAIL rand13_spacing op %0d got done=%b at %0d want 1 at 14", i, done13, n);
        break;
      end
      checks++;
      if (diff13 !== ed || borrow13 !== eb) begin
        errors++;
        $display("FAIL rand13 %h-%h got %h/%b want %h/%b", ra, rb, diff13, borrow13, ed, eb);
      end
      if (i == 999) begin
        start13 = 1'b0;
      end else begin
        ra = 13'($urandom_range(0, 8191));
        rb = 13'($urandom_range(0, 8191));
        a13 = ra; b13 = rb;
      end
      tick();
      n = 1;
    end
    start13 = 1'b0;
    for (int c = 0; c < 16; c++) tick();
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start13 = 1'b0; a13 = '0; b13 = '0;
    fs_a = 1'b0; fs_b = 1'b0; fs_bin = 1'b0;
    test_full_subtractor();
    test_reset();
    test_basic();
    test_vectors();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random8();
    test_random13();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b, LSB first, one bit per clock through a single full-subtractor cell plus a registered borrow.
- Arithmetic counterpart of the adder blocks: subtraction instead of addition, and sequential instead of combinational.
- Sits behind a start/busy/done handshake so a controller can issue operations back-to-back.
- Trades WIDTH cycles of latency for one-bit datapath area.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; a and b sampled on the same edge when accepted.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  single-cycle pulse: diff and borrow_out are valid.
- diff  output  WIDTH  result a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0. Internal shift registers, borrow flop and bit counter also clear.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: when start=1, load sa<=a, sb<=b, borrow<=0, cnt<=0, then go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each cycle, feed sa[0], sb[0] and borrow to the full_subtractor cell.
  - d = sa[0]^sb[0]^borrow.
  - bo = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&borrow).
  - Shift d into the MSB of the partial-result register (shift right); shift sa and sb right; borrow<=bo; cnt<=cnt+1.
  - When cnt==WIDTH-1, go to DONE. On that same edge, copy the final partial result to diff and the final bo to borrow_out.
- DONE: done=1 for exactly this one cycle, then back to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (load and go to SHIFT), which allows back-to-back operations.
- Latency: start sampled on edge k gives busy=1 for cycles k+1..k+WIDTH and done=1 in cycle k+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no reload and no error indication.
- diff and borrow_out change only on entry to DONE. They hold their value through IDLE and the next SHIFT until the next completion.
- a and b are don't-care except on the accepting edge.
- cnt width: $clog2(WIDTH). Wrap-around is never reached because the terminal count is checked explicitly.
- rst=1 in any state, including mid-SHIFT: on the next edge all registers return to their reset values; the in-flight operation is discarded and no done is issued.
- rst and start high on the same edge: reset wins.
- Signed use: diff is the correct two's-complement result. borrow_out is the unsigned borrow only; there is no overflow flag.

Decomposition:
- Shared arithmetic package holds:
  - state typedef (IDLE/SHIFT/DONE) as a localparam-encoded 2-bit type;
  - the WIDTH range limit constants.
- One natural sub-module: full_subtractor (combinational inputs A, B, Bin; outputs Diff, Bout), instantiated once in the SHIFT datapath.
- full_subtractor gets its own unit bench covering all 8 input combinations.

Test Plan:
- WIDTH=8, reset then a=0x35, b=0x12, start pulse -> busy high 8 cycles, done pulse at cycle 9, diff=0x23, borrow_out=0.
- a=0x12, b=0x35 -> diff=0xDD, borrow_out=1. a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
- Start a=0x80, b=0x01, then pulse start with a=0x00, b=0x00 at cycle 3 of SHIFT -> second start ignored; done at cycle 9 with diff=0x7F, borrow_out=0.
- Assert rst at cycle 4 of SHIFT -> next edge busy=0, done=0, diff=0, borrow_out=0; no done pulse in the following 12 cycles.
- Back-to-back: hold start=1 with a=0x10, b=0x01, then present a=0x05, b=0x07 in the DONE cycle -> first done diff=0x0F/borrow 0; second done exactly 9 cycles later, diff=0xFE/borrow 1.
- Random sweep of 1000 pairs, WIDTH=8 and WIDTH=13, checked against a reference model -> diff=(a-b) mod 2^WIDTH, borrow_out=(a<b), done spacing exactly WIDTH+1.
